// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables (DES 1-based bit numbers, bit 1 = MSB),
// the decrypt rotation schedule, the FSM state type and the permutation helpers.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Parity bits 8,16,...,64 never appear here, so they are dropped.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Right rotations for rounds 1..16; round 1 is zero so it yields K16 straight from PC1.
    localparam int SHIFT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[0], x[27:1]};
            2:       return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // DES keys carry odd parity per byte; an even-parity byte flags the key.
    function automatic logic key_parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) bad = bad | ~(^k[6'(8 * i) +: 8]);
        return bad;
    endfunction

endpackage

// File: rtl/des_f.sv
// Combinational DES Feistel function f(R,K): expand, mix subkey, S-box substitute, permute.
module des_f
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r,
    input  logic [SUBKEY_W-1:0] k,
    output logic [HALF_W-1:0]   f
);

    logic [SUBKEY_W-1:0] x;
    logic [HALF_W-1:0]   s;

    assign x = e_expand(r) ^ k;

    // Group 1 (x[47:42]) feeds sbox1 and lands in the top nibble.
    sbox1 u_sbox1 (.addr(x[47:42]), .dout(s[31:28]));
    sbox2 u_sbox2 (.addr(x[41:36]), .dout(s[27:24]));
    sbox3 u_sbox3 (.addr(x[35:30]), .dout(s[23:20]));
    sbox4 u_sbox4 (.addr(x[29:24]), .dout(s[19:16]));
    sbox5 u_sbox5 (.addr(x[23:18]), .dout(s[15:12]));
    sbox6 u_sbox6 (.addr(x[17:12]), .dout(s[11:8]));
    sbox7 u_sbox7 (.addr(x[11:6]),  .dout(s[7:4]));
    sbox8 u_sbox8 (.addr(x[5:0]),   .dout(s[3:0]));

    assign f = p_perm(s);

endmodule

// File: rtl/des_sbox.sv
// DES S-box lookups sbox1..sbox8. Table entry n (row*16+col) sits at bits [255-4n -: 4];
// row is {addr[5],addr[0]}, column is addr[4:1].
module sbox1 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox2 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox3 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox4 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox5 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox6 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox7 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

module sbox8 (input logic [5:0] addr, output logic [3:0] dout);
    localparam logic [255:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    assign dout = T[{~{addr[5], addr[0], addr[4:1]}, 2'b11} -: 4];
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryptor, one round per clock with subkeys K16..K1 generated on the fly.
// Optional key parity flag (output key_par_err) enabled by DES_KEY_PARITY_CHECK_EN.
module des_decrypt_core
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] ciphertext,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] plaintext
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic               key_par_err
`endif
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid must then stay high and data stable until that edge.
    state_t                state, state_nxt;
    logic [4:0]            round;
    logic [HALF_W-1:0]     l_q, r_q, f_out;
    logic [27:0]           c_q, d_q, c_rot, d_rot;
    logic [SUBKEY_W-1:0]   subkey;
    logic [BLOCK_W-1:0]    pt_q, ip_in;
    logic [55:0]           pc1_key;
    logic                  accept;
    int                    shift;

    assign accept  = in_valid && (state == IDLE);
    assign ip_in   = ip_perm(ciphertext);
    assign pc1_key = pc1_perm(key);
    assign shift   = SHIFT_T[4'(round - 5'd1)];
    assign c_rot   = ror28(c_q, shift);
    assign d_rot   = ror28(d_q, shift);
    assign subkey  = pc2_perm({c_rot, d_rot});

    des_f u_des_f (.r(r_q), .k(subkey), .f(f_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROUND;
            ROUND:   if (round == LAST_ROUND) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round <= '0;
            l_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            pt_q  <= '0;
        end else if (accept) begin
            {l_q, r_q} <= ip_in;
            {c_q, d_q} <= pc1_key;
            round      <= 5'd1;
        end else if (state == ROUND) begin
            l_q <= r_q;
            r_q <= l_q ^ f_out;
            c_q <= c_rot;
            d_q <= d_rot;
            if (round == LAST_ROUND) begin
                // Final swap: preoutput is R16||L16.
                pt_q  <= fp_perm({l_q ^ f_out, r_q});
                round <= '0;
            end else begin
                round <= round + 5'd1;
            end
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      key_par_err <= 1'b0;
        else if (accept) key_par_err <= key_parity_bad(key);
    end
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign plaintext = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known DES vectors, latency, backpressure,
// back-to-back, mid-block reset, input scrambling, and key parity (DES_KEY_PARITY_CHECK_EN).
module tb_des_decrypt_core;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] P2 = 64'h8787878787878787;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ciphertext = '0;
    logic [63:0] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] plaintext;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        key_par_err;
`endif

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    des_decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .key_par_err(key_par_err)
`endif
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard: every completed output handshake must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", {63'd0, out_valid}, 64'd0);
            else check("plaintext", plaintext, exp_q.pop_front());
        end
    end

    // driver: present one block and return just after its accept edge
    task automatic send(input logic [63:0] c, input logic [63:0] k);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; ciphertext = c; key = k;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!out_valid && lat < 100);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat, t1, t2;
        bit seen;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_plaintext", plaintext, 64'd0);

        // vector 1, latency
        exp_q.push_back(P1);
        send(C1, K1);
        wait_valid(lat);
        check("latency", 64'(lat), 64'd16);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("after_done_valid", {63'd0, out_valid}, 64'd0);
        check("after_done_ready", {63'd0, in_ready}, 64'd1);

        // vector 2 with output backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        exp_q.push_back(P2);
        send(C2, K2);
        wait_valid(lat);
        check("latency2", 64'(lat), 64'd16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_pt", plaintext, P2);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // back-to-back with in_valid held high
        @(posedge clk); #1;
        in_valid = 1'b1; ciphertext = C1; key = K1;
        exp_q.push_back(P1);
        @(posedge clk); #1;
        t1 = cyc;
        ciphertext = C2; key = K2;
        exp_q.push_back(P2);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        t2 = cyc;
        in_valid = 1'b0;
        check("b2b_accept_gap", 64'(t2 - t1), 64'd18);
        wait_drain();

        // reset in the middle of a block
        send(C1, K1);
        repeat (7) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        check("abort_pt", plaintext, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", {63'd0, seen}, 64'd0);
        exp_q.push_back(P1);
        send(C1, K1);
        wait_drain();

        // inputs scrambled while rounds run
        exp_q.push_back(P2);
        send(C2, K2);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            ciphertext = {$urandom, $urandom};
            key        = {$urandom, $urandom};
            in_valid   = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        wait_drain();

`ifdef DES_KEY_PARITY_CHECK_EN
        exp_q.push_back(P1);
        send(C1, 64'h133457799BBCDFF0);
        check("par_err_bad", {63'd0, key_par_err}, 64'd1);
        wait_drain();
        check("par_err_held", {63'd0, key_par_err}, 64'd1);
        exp_q.push_back(P1);
        send(C1, K1);
        check("par_err_good", {63'd0, key_par_err}, 64'd0);
        wait_drain();
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
